cim_row_sequencer: RTL and testbench

//  Parametrised N-row sequencer for the memristor time-domain CIM array: runs WRITE, multi-loop READ
//  and discharge RESET phases with per-row PWM wordline gating, a command handshake and row masking.

---
 rtl/cim_row_sequencer_pkg.sv | 15 +
 rtl/cim_row_sequencer_if.sv | 25 ++
 rtl/cim_pwm_bank.sv | 34 +++
 rtl/cim_row_sequencer.sv | 136 +++++++++++++
 tb/tb_cim_row_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_row_sequencer_pkg.sv
// Shared definitions for the CIM row sequencer: phase state encodings and
// opcode field values (opcode[3:2]).
package cim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESET = 3'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

endpackage

// File: rtl/cim_row_sequencer_if.sv
// Host command interface for the CIM row sequencer.
//   cmd_valid  host -> seq  command request
//   cmd_ready  seq -> host  high only while the sequencer is idle
//   opcode     host -> seq  [3:2] selects WRITE/READ/no-op, [1:0] reserved
//   cmd_loops  host -> seq  READ loop count (0 selects the default)
//   row_en     host -> seq  row mask, latched when the command is accepted
interface cim_row_sequencer_if #(
  parameter int N_ROWS = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        opcode;
  logic [3:0]        cmd_loops;
  logic [N_ROWS-1:0] row_en;

  modport master (
    output cmd_valid, opcode, cmd_loops, row_en,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, opcode, cmd_loops, row_en,
    output cmd_ready
  );
endinterface

// File: rtl/cim_pwm_bank.sv
// Per-row PWM generator sharing one free-running counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   pixel_data   N_ROWS packed pixel words; the top PWM_W bits of each are the duty
//   pwm          registered per-row PWM, high while counter < duty
// Duties latch only when the counter is 0 so every period is glitch-free.
module cim_pwm_bank #(
  parameter int N_ROWS = 4,
  parameter int DATA_W = 10,
  parameter int PWM_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_ROWS*DATA_W-1:0] pixel_data,
  output logic [N_ROWS-1:0]        pwm
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty [N_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= '0;
      for (int unsigned r = 0; r < N_ROWS; r++) duty[r] <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      for (int unsigned r = 0; r < N_ROWS; r++) begin
        if (cnt == '0) duty[r] <= pixel_data[r*DATA_W + DATA_W - 1 -: PWM_W];
        pwm[r] <= (cnt < duty[r]);
      end
    end
  end

endmodule

// File: rtl/cim_row_sequencer.sv
// Phase sequencer for one memristor time-domain CIM tile: WRITE, multi-loop
// READ and discharge RESET phases with masked PWM wordline gating.
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd                  host command interface (slave side)
//   abort                forces an early discharge from WRITE or READ
//   pixel_data           per-row pixel words feeding the PWM bank
//   weight_ctrl          high for the first T_WEIGHT cycles of WRITE
//   compute_sig          high for the whole READ phase
//   input_ctrl           high for the first T_INPUT cycles of each READ loop
//   pre_charge_ctrl      active-low, low from timer T_PRE in READ loops and RESET
//   wl_ctrl              compute_sig & pwm & latched row mask
//   level_shifted_input  raw per-row PWM
//   busy, done           not idle / one-cycle pulse on return to IDLE from WRITE or RESET
//   state_debug          current state encoding
module cim_row_sequencer
  import cim_ctrl_pkg::*;
#(
  parameter int N_ROWS     = 4,
  parameter int DATA_W     = 10,
  parameter int PWM_W      = 7,
  parameter int TIMER_W    = 10,
  parameter int T_WRITE    = 720,
  parameter int T_WEIGHT   = 30,
  parameter int T_CYC      = 54,
  parameter int T_INPUT    = 30,
  parameter int T_PRE      = 42,
  parameter int READ_LOOPS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cim_row_sequencer_if.slave       cmd,
  input  logic                     abort,
  input  logic [N_ROWS*DATA_W-1:0] pixel_data,
  output logic                     weight_ctrl,
  output logic                     compute_sig,
  output logic                     input_ctrl,
  output logic                     pre_charge_ctrl,
  output logic [N_ROWS-1:0]        wl_ctrl,
  output logic [N_ROWS-1:0]        level_shifted_input,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state_debug
);

  localparam logic [TIMER_W-1:0] WR_LAST  = TIMER_W'(T_WRITE - 1);
  localparam logic [TIMER_W-1:0] CYC_LAST = TIMER_W'(T_CYC - 1);
  localparam logic [TIMER_W-1:0] WEIGHT_T = TIMER_W'(T_WEIGHT);
  localparam logic [TIMER_W-1:0] INPUT_T  = TIMER_W'(T_INPUT);
  localparam logic [TIMER_W-1:0] PRE_T    = TIMER_W'(T_PRE);

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer;
  logic [3:0]          loop_cnt;
  logic [3:0]          loop_lim;
  logic [N_ROWS-1:0]   mask;
  logic [N_ROWS-1:0]   pwm;
  logic                accept;
  logic                loop_end;

  cim_pwm_bank #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W),
    .PWM_W  (PWM_W)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_data (pixel_data),
    .pwm        (pwm)
  );

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state == ST_IDLE);
  assign loop_end      = (timer == CYC_LAST);

  always_comb begin
    state_n         = state;
    weight_ctrl     = 1'b0;
    compute_sig     = 1'b0;
    input_ctrl      = 1'b0;
    pre_charge_ctrl = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.opcode[3:2] == OP_WRITE)     state_n = ST_WRITE;
          else if (cmd.opcode[3:2] == OP_READ) state_n = ST_READ;
        end
      end
      ST_WRITE: begin
        weight_ctrl = (timer < WEIGHT_T);
        if (abort)                 state_n = ST_RESET;
        else if (timer == WR_LAST) state_n = ST_IDLE;
      end
      ST_READ: begin
        compute_sig     = 1'b1;
        input_ctrl      = (timer < INPUT_T);
        pre_charge_ctrl = !(timer >= PRE_T);
        if (abort) state_n = ST_RESET;
        else if (loop_end && (loop_cnt == loop_lim - 4'd1)) state_n = ST_RESET;
      end
      ST_RESET: begin
        pre_charge_ctrl = !(timer >= PRE_T);
        if (loop_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      loop_cnt <= '0;
      loop_lim <= '0;
      mask     <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= ((state == ST_WRITE) || (state == ST_RESET)) && (state_n == ST_IDLE);
      if ((state_n != state) || (state == ST_IDLE)) timer <= '0;
      else if ((state == ST_READ) && loop_end)     timer <= '0;
      else                                          timer <= timer + 1'b1;
      if (state_n != state)                     loop_cnt <= '0;
      else if ((state == ST_READ) && loop_end)  loop_cnt <= loop_cnt + 4'd1;
      if (accept) begin
        mask     <= cmd.row_en;
        loop_lim <= (cmd.cmd_loops == 4'd0) ? 4'(READ_LOOPS) : cmd.cmd_loops;
      end
    end
  end

  assign wl_ctrl             = {N_ROWS{compute_sig}} & pwm & mask;
  assign level_shifted_input = pwm;
  assign busy                = (state != ST_IDLE);
  assign state_debug         = state;

endmodule

// File: tb/tb_cim_row_sequencer.sv
module tb_cim_row_sequencer;

  localparam int N   = 4;
  localparam int DW  = 10;
  localparam int TW  = 720;
  localparam int TWT = 30;
  localparam int TC  = 54;
  localparam int TI  = 30;
  localparam int TP  = 42;
  localparam int RL  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cim_row_sequencer_if #(.N_ROWS(N)) cmd_if ();

  logic            abort;
  logic [N*DW-1:0] pixel_data;
  logic            weight_ctrl, compute_sig, input_ctrl, pre_charge_ctrl;
  logic [N-1:0]    wl_ctrl, level_shifted_input;
  logic            busy, done;
  logic [2:0]      state_debug;

  cim_row_sequencer #(
    .N_ROWS(N), .DATA_W(DW), .PWM_W(7), .TIMER_W(10), .T_WRITE(TW), .T_WEIGHT(TWT),
    .T_CYC(TC), .T_INPUT(TI), .T_PRE(TP), .READ_LOOPS(RL)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd                 (cmd_if),
    .abort               (abort),
    .pixel_data          (pixel_data),
    .weight_ctrl         (weight_ctrl),
    .compute_sig         (compute_sig),
    .input_ctrl          (input_ctrl),
    .pre_charge_ctrl     (pre_charge_ctrl),
    .wl_ctrl             (wl_ctrl),
    .level_shifted_input (level_shifted_input),
    .busy                (busy),
    .done                (done),
    .state_debug         (state_debug)
  );

  typedef struct {
    int st1, st2, st3, weight, inp, pclow;
    logic [N*16-1:0] wl_min, wl_max;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   duty[N];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: phase lengths and pulse counts from the phase rules.
  function automatic exp_t build_exp(input int op, input int loops, input int abort_at,
                                     input logic [N-1:0] rowen);
    exp_t e;
    int   nl, rc, lo, hi, w;
    e = '{default: 0};
    if (op == 1) begin
      rc = (abort_at >= 0) ? abort_at + 1 : TW;
      e.st1 = rc;
      e.weight = (rc < TWT) ? rc : TWT;
      if (abort_at >= 0) begin
        e.st3 = TC;
        e.pclow = TC - TP;
      end
    end else begin
      nl = (loops == 0) ? RL : loops;
      rc = (abort_at >= 0) ? abort_at + 1 : nl * TC;
      e.st2 = rc;
      for (int t = 0; t < rc; t++) begin
        if ((t % TC) < TI) e.inp++;
        if ((t % TC) >= TP) e.pclow++;
      end
      e.st3 = TC;
      e.pclow += TC - TP;
    end
    w = e.st2;
    for (int r = 0; r < N; r++) begin
      if (!rowen[r] || duty[r] == 0) begin
        lo = 0; hi = 0;
      end else if (duty[r] == 127) begin
        lo = w - (w + 127) / 128; hi = w - w / 128;
      end else begin
        lo = 0; hi = w;
      end
      e.wl_min[r*16 +: 16] = 16'(lo);
      e.wl_max[r*16 +: 16] = 16'(hi);
    end
    return e;
  endfunction

  // Monitor: accumulates per-transaction activity, compares on each done pulse.
  int   a_st1, a_st2, a_st3, a_busy, a_comp, a_w, a_in, a_pc, viol;
  int   a_wl[N];
  logic prev_busy;

  function automatic void clear_acc();
    a_st1 = 0; a_st2 = 0; a_st3 = 0; a_busy = 0; a_comp = 0;
    a_w = 0; a_in = 0; a_pc = 0; viol = 0;
    for (int r = 0; r < N; r++) a_wl[r] = 0;
  endfunction

  initial begin
    clear_acc();
    prev_busy = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      clear_acc();
      prev_busy = 1'b0;
    end else begin
      if (cmd_if.cmd_ready !== !busy) viol++;
      if (busy !== (state_debug != 3'd0)) viol++;
      if (compute_sig !== (state_debug == 3'd2)) viol++;
      if (!compute_sig && wl_ctrl != '0) viol++;
      if (!busy && (weight_ctrl || input_ctrl || !pre_charge_ctrl)) viol++;
      if (busy) begin
        a_busy++;
        if (state_debug == 3'd1) a_st1++;
        if (state_debug == 3'd2) a_st2++;
        if (state_debug == 3'd3) a_st3++;
        if (compute_sig) a_comp++;
        if (weight_ctrl) a_w++;
        if (input_ctrl) a_in++;
        if (!pre_charge_ctrl) a_pc++;
        for (int r = 0; r < N; r++) if (wl_ctrl[r]) a_wl[r]++;
      end
      if (done) begin
        if (busy || !prev_busy) viol++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with no command pending, expected none");
        end else begin
          e = sb.pop_front();
          check("write_cycles", a_st1, e.st1);
          check("read_cycles", a_st2, e.st2);
          check("reset_cycles", a_st3, e.st3);
          check("busy_cycles", a_busy, e.st1 + e.st2 + e.st3);
          check("compute_cycles", a_comp, e.st2);
          check("weight_hi", a_w, e.weight);
          check("input_hi", a_in, e.inp);
          check("precharge_lo", a_pc, e.pclow);
          for (int r = 0; r < N; r++)
            check_range($sformatf("wl_row%0d", r), a_wl[r],
                        int'(e.wl_min[r*16 +: 16]), int'(e.wl_max[r*16 +: 16]));
          check("protocol_viol", viol, 0);
        end
        clear_acc();
      end
      prev_busy = busy;
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((sb.size() != 0 || cmd_if.cmd_ready !== 1'b1) && k < budget) begin
      cycle(1);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", k);
    end
  endtask

  // Apply duties, let them settle, then check one full PWM period per row.
  task automatic apply_pixels();
    int   cnt[N];
    logic [6:0] d7;
    logic [2:0] lo3;
    for (int r = 0; r < N; r++) begin
      d7  = 7'(duty[r]);
      lo3 = 3'($urandom);
      pixel_data[r*DW +: DW] = {d7, lo3};
      cnt[r] = 0;
    end
    cycle(300);
    repeat (128) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) if (level_shifted_input[r]) cnt[r]++;
    end
    cycle(1);
    for (int r = 0; r < N; r++) check($sformatf("pwm_duty_row%0d", r), cnt[r], duty[r]);
  endtask

  task automatic run_cmd(input int op, input int loops, input logic [N-1:0] rowen,
                         input int abort_at);
    logic [1:0] opf;
    logic [1:0] rsv;
    opf = 2'(op);
    rsv = 2'($urandom);
    if (op == 1 || op == 2) sb.push_back(build_exp(op, loops, abort_at, rowen));
    cmd_if.opcode    = {opf, rsv};
    cmd_if.cmd_loops = 4'(loops);
    cmd_if.row_en    = rowen;
    cmd_if.cmd_valid = 1'b1;
    cycle(1);
    cmd_if.cmd_valid = 1'b0;
    if (op == 0 || op == 3) begin
      cycle(3);
      check("noop_busy", int'(busy), 0);
      check("noop_state", int'(state_debug), 0);
    end
    if (abort_at >= 0) begin
      cycle(abort_at);
      abort = 1'b1;
    end
    wait_idle(2000);
    abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_precharge"}, int'(pre_charge_ctrl), 1);
    check({tag, "_ready"}, int'(cmd_if.cmd_ready), 1);
    check({tag, "_weight"}, int'(weight_ctrl), 0);
    check({tag, "_compute"}, int'(compute_sig), 0);
    check({tag, "_input"}, int'(input_ctrl), 0);
    check({tag, "_wl"}, int'(wl_ctrl), 0);
    check({tag, "_lsi"}, int'(level_shifted_input), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_state"}, int'(state_debug), 0);
  endtask

  initial begin
    int op, loops, ab, pick;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.opcode    = '0;
    cmd_if.cmd_loops = '0;
    cmd_if.row_en    = '0;
    abort            = 1'b0;
    pixel_data       = '0;
    #2;
    check_reset_outputs("reset");
    cycle(2);
    rst_n = 1'b1;
    cycle(1);
    check("post_reset_ready", int'(cmd_if.cmd_ready), 1);
    check("post_reset_precharge", int'(pre_charge_ctrl), 1);

    duty[0] = 0; duty[1] = 64; duty[2] = 127; duty[3] = 32;
    apply_pixels();

    run_cmd(1, 0, 4'b1111, -1);
    run_cmd(0, 0, 4'b1111, -1);
    run_cmd(3, 5, 4'b1111, -1);
    run_cmd(2, 0, 4'b1111, -1);
    run_cmd(2, 3, 4'b0101, -1);
    run_cmd(2, 5, 4'b1111, 2 * TC + 10);
    run_cmd(1, 0, 4'b1111, 200);

    // Async reset in the middle of a WRITE: no done, reset values immediately.
    cmd_if.opcode    = 4'b0100;
    cmd_if.row_en    = 4'b1111;
    cmd_if.cmd_valid = 1'b1;
    cycle(1);
    cmd_if.cmd_valid = 1'b0;
    cycle(100);
    check("mid_write_weight_low", int'(weight_ctrl), 0);
    check("mid_write_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cycle(2);
    rst_n = 1'b1;
    cycle(1);
    apply_pixels();
    run_cmd(2, 2, 4'b1111, -1);

    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        for (int r = 0; r < N; r++) begin
          pick = int'($urandom_range(3, 0));
          duty[r] = (pick == 0) ? 0 : (pick == 1) ? 127 : int'($urandom_range(127, 0));
        end
        apply_pixels();
      end
      op = int'($urandom_range(3, 0));
      loops = int'($urandom_range(4, 0));
      ab = -1;
      if ($urandom_range(2, 0) == 0) begin
        if (op == 1) ab = int'($urandom_range(TW - 1, 0));
        if (op == 2) ab = int'($urandom_range(((loops == 0) ? RL : loops) * TC - 1, 0));
      end
      run_cmd(op, loops, 4'($urandom), ab);
    end

    cycle(2);
    check("final_protocol_viol", viol, 0);
    check("final_pending", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
